// File: rtl/dest_ip_tbl_ctrl.sv
// Command/response front end for the destination-IP table: one outstanding
// read, write or clear-all sweep, with ack timeout and saturating statistics.
module dest_ip_tbl_ctrl #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_TBL_ADDR_WIDTH   = 5,
    parameter int C_TIMEOUT          = 16
) (
    input  logic                          AXI_ACLK,
    input  logic                          AXI_RESET,

    // Command/response handshakes: a transfer happens on any rising edge where
    // valid and ready are both high; valid holds its payload until then.
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [C_TBL_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] cmd_wdata,

    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [C_S_AXI_DATA_WIDTH-1:0] resp_rdata,
    output logic                          resp_err,

    output logic                          tbl_rd_req,
    output logic                          tbl_wr_req,
    output logic [C_TBL_ADDR_WIDTH-1:0]   tbl_rd_addr,
    output logic [C_TBL_ADDR_WIDTH-1:0]   tbl_wr_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
    input  logic                          tbl_rd_ack,
    input  logic                          tbl_wr_ack,

    output logic [31:0]                   wr_count,
    output logic [31:0]                   rd_count,
    output logic [31:0]                   timeout_count,

    output logic [2:0]                    dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_WAIT     = 3'd2,
        S_CLR_REQ  = 3'd3,
        S_CLR_WAIT = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    localparam int CW = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
    localparam logic [CW-1:0]               TO_LAST  = CW'(C_TIMEOUT - 1);
    localparam logic [C_TBL_ADDR_WIDTH-1:0] IDX_LAST = '1;

    state_t                          state_q;
    logic                            is_wr_q;
    logic [CW-1:0]                   tmo_q;
    logic [C_TBL_ADDR_WIDTH-1:0]     idx_q;
    logic                            rd_req_q;
    logic                            wr_req_q;
    logic [C_TBL_ADDR_WIDTH-1:0]     rd_addr_q;
    logic [C_TBL_ADDR_WIDTH-1:0]     wr_addr_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data_q;
    logic                            resp_valid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   resp_rdata_q;
    logic                            resp_err_q;
    logic [31:0]                     wr_cnt_q;
    logic [31:0]                     rd_cnt_q;
    logic [31:0]                     to_cnt_q;
    logic                            cmd_accept;
    logic                            op_ack;
    logic [C_TBL_ADDR_WIDTH-1:0]     idx_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Ready is decoded from state so it is visible on the first cycle out of reset.
    assign cmd_ready  = (state_q == S_IDLE) && !AXI_RESET;
    assign cmd_accept = cmd_valid && cmd_ready;
    assign op_ack     = is_wr_q ? tbl_wr_ack : tbl_rd_ack;
    assign idx_d      = idx_q + 1'b1;

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            state_q      <= S_IDLE;
            is_wr_q      <= 1'b0;
            tmo_q        <= '0;
            idx_q        <= '0;
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            to_cnt_q     <= '0;
        end else begin
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_accept) begin
                        tmo_q        <= '0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                        case (cmd_op)
                            2'd0: begin
                                is_wr_q   <= 1'b0;
                                rd_req_q  <= 1'b1;
                                rd_addr_q <= cmd_addr;
                                state_q   <= S_REQ;
                            end
                            2'd1: begin
                                is_wr_q   <= 1'b1;
                                wr_req_q  <= 1'b1;
                                wr_addr_q <= cmd_addr;
                                wr_data_q <= cmd_wdata;
                                state_q   <= S_REQ;
                            end
                            2'd2: begin
                                is_wr_q   <= 1'b1;
                                idx_q     <= '0;
                                wr_req_q  <= 1'b1;
                                wr_addr_q <= '0;
                                wr_data_q <= '0;
                                state_q   <= S_CLR_REQ;
                            end
                            default: begin
                                resp_valid_q <= 1'b1;
                                resp_err_q   <= 1'b1;
                                state_q      <= S_RESP;
                            end
                        endcase
                    end
                end
                S_REQ: begin
                    tmo_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // An ack on the last counted cycle still wins over the timeout.
                    if (op_ack) begin
                        if (is_wr_q) begin
                            wr_cnt_q <= sat_inc(wr_cnt_q);
                        end else begin
                            rd_cnt_q     <= sat_inc(rd_cnt_q);
                            resp_rdata_q <= tbl_rd_data;
                        end
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end else if (tmo_q == TO_LAST) begin
                        to_cnt_q     <= sat_inc(to_cnt_q);
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_CLR_REQ: begin
                    tmo_q   <= '0;
                    state_q <= S_CLR_WAIT;
                end
                S_CLR_WAIT: begin
                    if (tbl_wr_ack) begin
                        wr_cnt_q <= sat_inc(wr_cnt_q);
                        if (idx_q == IDX_LAST) begin
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else begin
                            idx_q     <= idx_d;
                            wr_req_q  <= 1'b1;
                            wr_addr_q <= idx_d;
                            state_q   <= S_CLR_REQ;
                        end
                    end else if (tmo_q == TO_LAST) begin
                        to_cnt_q     <= sat_inc(to_cnt_q);
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign tbl_rd_req    = rd_req_q;
    assign tbl_wr_req    = wr_req_q;
    assign tbl_rd_addr   = rd_addr_q;
    assign tbl_wr_addr   = wr_addr_q;
    assign tbl_wr_data   = wr_data_q;
    assign wr_count      = wr_cnt_q;
    assign rd_count      = rd_cnt_q;
    assign timeout_count = to_cnt_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_dest_ip_tbl_ctrl.sv
// Directed bench for dest_ip_tbl_ctrl: a negedge table responder plus one task per scenario.
module tb_dest_ip_tbl_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, resp_valid, resp_ready, resp_err;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr, tbl_rd_addr, tbl_wr_addr;
    logic [DW-1:0] cmd_wdata, resp_rdata, tbl_wr_data, tbl_rd_data;
    logic          tbl_rd_req, tbl_wr_req, tbl_rd_ack, tbl_wr_ack;
    logic [31:0]   wr_count, rd_count, timeout_count;
    logic [2:0]    dbg_state;

    int errors = 0;
    int checks = 0;

    logic          auto_ack = 1'b0;
    logic [DW-1:0] rd_value = '0;
    logic          prev_wr, prev_rd;
    logic [DW-1:0] wr_log_addr[$];
    logic [DW-1:0] wr_log_data[$];
    logic [DW-1:0] exp_q[$];
    int            wr_pulses = 0;
    int            double_pulse = 0;

    dest_ip_tbl_ctrl #(
        .C_S_AXI_DATA_WIDTH(DW), .C_TBL_ADDR_WIDTH(AW), .C_TIMEOUT(TO)
    ) dut (
        .AXI_ACLK(clk), .AXI_RESET(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .tbl_rd_req(tbl_rd_req), .tbl_wr_req(tbl_wr_req),
        .tbl_rd_addr(tbl_rd_addr), .tbl_wr_addr(tbl_wr_addr),
        .tbl_wr_data(tbl_wr_data), .tbl_rd_data(tbl_rd_data),
        .tbl_rd_ack(tbl_rd_ack), .tbl_wr_ack(tbl_wr_ack),
        .wr_count(wr_count), .rd_count(rd_count), .timeout_count(timeout_count),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Table model: logs every write pulse and, when enabled, acks one cycle after a request.
    always @(negedge clk) begin
        if (tbl_wr_req) begin
            wr_log_addr.push_back(DW'(tbl_wr_addr));
            wr_log_data.push_back(tbl_wr_data);
            wr_pulses++;
            if (prev_wr) double_pulse++;
        end
        if (auto_ack) begin
            tbl_wr_ack  = prev_wr;
            tbl_rd_ack  = prev_rd;
            tbl_rd_data = rd_value;
        end
        prev_wr = tbl_wr_req;
        prev_rd = tbl_rd_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wd;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL cmd_accept: cmd_ready=%0b required 1 within 50 cycles", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_resp(input int limit);
        int n;
        n = 0;
        while (!resp_valid && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL resp_wait: resp_valid=%0b required 1 within %0d cycles", resp_valid, limit);
        end
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL resp_done: resp_valid=%0b cmd_ready=%0b required 0/1", resp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({cmd_ready, resp_valid, resp_err, tbl_rd_req, tbl_wr_req} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00000",
                     {cmd_ready, resp_valid, resp_err, tbl_rd_req, tbl_wr_req});
        end
        checks++;
        if ({wr_count, rd_count, timeout_count} !== 96'h0 || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_counts: wr=%h rd=%h to=%h rdata=%h required 0",
                     wr_count, rd_count, timeout_count, resp_rdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_release: cmd_ready=%0b state=%0d required 1/0", cmd_ready, dbg_state);
        end
    endtask

    task automatic test_write();
        auto_ack = 1'b1;
        send_cmd(2'd1, 5'd3, 32'h0A00_0001);
        checks++;
        if (tbl_wr_req !== 1'b1 || tbl_rd_req !== 1'b0 || tbl_wr_addr !== 5'd3 ||
            tbl_wr_data !== 32'h0A00_0001 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_req: wr_req=%0b rd_req=%0b addr=%0d data=%h rdy=%0b required 1/0/3/0a000001/0",
                     tbl_wr_req, tbl_rd_req, tbl_wr_addr, tbl_wr_data, cmd_ready);
        end
        tick();
        checks++;
        if (tbl_wr_req !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL write_pulse: wr_req=%0b resp_valid=%0b required 0/0", tbl_wr_req, resp_valid);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0 || wr_count !== 32'd1) begin
            errors++;
            $display("FAIL write_resp: valid=%0b err=%0b rdata=%h wr_count=%0d required 1/0/0/1",
                     resp_valid, resp_err, resp_rdata, wr_count);
        end
        finish_resp();
    endtask

    task automatic test_read();
        rd_value = 32'h0A00_0001;
        send_cmd(2'd0, 5'd3, 32'hFFFF_FFFF);
        checks++;
        if (tbl_rd_req !== 1'b1 || tbl_wr_req !== 1'b0 || tbl_rd_addr !== 5'd3) begin
            errors++;
            $display("FAIL read_req: rd_req=%0b wr_req=%0b addr=%0d required 1/0/3",
                     tbl_rd_req, tbl_wr_req, tbl_rd_addr);
        end
        tick();
        tick();
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0A00_0001 ||
            rd_count !== 32'd1 || wr_count !== 32'd1) begin
            errors++;
            $display("FAIL read_resp: valid=%0b err=%0b rdata=%h rd=%0d wr=%0d required 1/0/0a000001/1/1",
                     resp_valid, resp_err, resp_rdata, rd_count, wr_count);
        end
        finish_resp();
    endtask

    task automatic test_timeout();
        int n;
        auto_ack   = 1'b0;
        tbl_rd_ack = 1'b0;
        tbl_wr_ack = 1'b0;
        send_cmd(2'd0, 5'd5, 32'h0);
        tick();
        n = 0;
        while (!resp_valid && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n !== TO) begin
            errors++;
            $display("FAIL timeout_latency: %0d cycles after wait entry, required %0d", n, TO);
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0 ||
            timeout_count !== 32'd1 || rd_count !== 32'd1) begin
            errors++;
            $display("FAIL timeout_resp: valid=%0b err=%0b rdata=%h to=%0d rd=%0d required 1/1/0/1/1",
                     resp_valid, resp_err, resp_rdata, timeout_count, rd_count);
        end
        finish_resp();
    endtask

    task automatic test_reserved();
        send_cmd(2'd3, 5'd9, 32'h1234_5678);
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1 || tbl_rd_req !== 1'b0 || tbl_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL reserved_op: valid=%0b err=%0b rd_req=%0b wr_req=%0b required 1/1/0/0",
                     resp_valid, resp_err, tbl_rd_req, tbl_wr_req);
        end
        finish_resp();
        checks++;
        if (wr_count !== 32'd1 || rd_count !== 32'd1 || timeout_count !== 32'd1) begin
            errors++;
            $display("FAIL reserved_counts: wr=%0d rd=%0d to=%0d required 1/1/1", wr_count, rd_count, timeout_count);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        auto_ack = 1'b1;
        rd_value = 32'h1234_5678;
        send_cmd(2'd0, 5'd7, 32'h0);
        wait_resp(10);
        auto_ack   = 1'b0;
        tbl_rd_ack = 1'b0;
        tbl_wr_ack = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tbl_rd_ack  = (i == 4);
            tbl_rd_data = (i == 4) ? 32'hDEAD_BEEF : 32'h0;
            tick();
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h1234_5678 || resp_err !== 1'b0 || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: valid=%0b rdata=%h err=%0b rdy=%0b required 1/12345678/0/0",
                         i, resp_valid, resp_rdata, resp_err, cmd_ready);
            end
        end
        tbl_rd_ack = 1'b0;
        checks++;
        if (rd_count !== 32'd2) begin
            errors++;
            $display("FAIL stray_ack: rd_count=%0d required 2", rd_count);
        end
        finish_resp();
    endtask

    task automatic test_clear_all();
        int bad_addr, bad_data;
        auto_ack = 1'b1;
        wr_log_addr.delete();
        wr_log_data.delete();
        exp_q.delete();
        wr_pulses    = 0;
        double_pulse = 0;
        for (int i = 0; i < 32; i++) exp_q.push_back(DW'(i));
        send_cmd(2'd2, 5'd17, 32'hFFFF_FFFF);
        wait_resp(200);
        checks++;
        if (wr_pulses !== 32 || double_pulse !== 0) begin
            errors++;
            $display("FAIL clear_pulses: pulses=%0d back_to_back=%0d required 32/0", wr_pulses, double_pulse);
        end
        bad_addr = 0;
        bad_data = 0;
        while (exp_q.size() > 0 && wr_log_addr.size() > 0) begin
            if (wr_log_addr.pop_front() !== exp_q.pop_front()) bad_addr++;
            if (wr_log_data.pop_front() !== 32'h0) bad_data++;
        end
        checks++;
        if (bad_addr !== 0 || bad_data !== 0) begin
            errors++;
            $display("FAIL clear_sequence: addr_errs=%0d data_errs=%0d required 0/0", bad_addr, bad_data);
        end
        checks++;
        if (resp_err !== 1'b0 || resp_rdata !== 32'h0 || wr_count !== 32'd33) begin
            errors++;
            $display("FAIL clear_resp: err=%0b rdata=%h wr_count=%0d required 0/0/33", resp_err, resp_rdata, wr_count);
        end
        finish_resp();
        repeat (5) tick();
        checks++;
        if (resp_valid !== 1'b0 || wr_pulses !== 32) begin
            errors++;
            $display("FAIL clear_single_resp: valid=%0b pulses=%0d required 0/32", resp_valid, wr_pulses);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n, p;
        auto_ack = 1'b1;
        send_cmd(2'd2, 5'd0, 32'h0);
        n = 0;
        while (!(tbl_wr_req && tbl_wr_addr == 5'd10) && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (!(tbl_wr_req === 1'b1 && tbl_wr_addr === 5'd10)) begin
            errors++;
            $display("FAIL sweep_reach10: wr_req=%0b addr=%0d required 1/10", tbl_wr_req, tbl_wr_addr);
        end
        rst = 1'b1;
        tick();
        p = wr_pulses;
        checks++;
        if ({cmd_ready, resp_valid, resp_err, tbl_rd_req, tbl_wr_req} !== 5'b0 ||
            tbl_wr_addr !== 5'd0 || tbl_rd_addr !== 5'd0 || tbl_wr_data !== 32'h0 || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs: flags=%b wa=%0d ra=%0d wd=%h rdata=%h required all 0",
                     {cmd_ready, resp_valid, resp_err, tbl_rd_req, tbl_wr_req},
                     tbl_wr_addr, tbl_rd_addr, tbl_wr_data, resp_rdata);
        end
        checks++;
        if ({wr_count, rd_count, timeout_count} !== 96'h0 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL midreset_counts: wr=%0d rd=%0d to=%0d state=%0d required 0",
                     wr_count, rd_count, timeout_count, dbg_state);
        end
        repeat (2) tick();
        rst = 1'b0;
        repeat (40) tick();
        checks++;
        if (wr_pulses !== p || resp_valid !== 1'b0 || cmd_ready !== 1'b1 || wr_count !== 32'd0) begin
            errors++;
            $display("FAIL midreset_quiet: pulses=%0d/%0d valid=%0b rdy=%0b wr=%0d required %0d/0/1/0",
                     wr_pulses, p, resp_valid, cmd_ready, wr_count, p);
        end
    endtask

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 2'd0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        resp_ready  = 1'b0;
        tbl_rd_data = '0;
        tbl_rd_ack  = 1'b0;
        tbl_wr_ack  = 1'b0;
        prev_wr     = 1'b0;
        prev_rd     = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_reserved();
        test_backpressure();
        test_clear_all();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
